pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the program counter of the pipelined MIPS core and decides, every cycle, where fetch goes next. Arbitrates between sequential fetch, hazard stall, D-stage branch/jump targets (from the NPC calculator), `jr` register targets, exception/interrupt entry and `eret` return. Runs a small redirect state machine so stale D-stage requests cannot override a redirect, and drives the F/D/E flush line. Flags misaligned or out-of-range fetch addresses for CP0.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset
- `EXC_VECTOR`, 32'h0000_4180, exception/interrupt handler entry
- `IMEM_LO`, 32'h0000_3000, lowest legal fetch address
- `IMEM_HI`, 32'h0000_6ffc, highest legal fetch address
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  hazard unit freeze of PC and F/D
- `npc_op`  in  1  D-stage branch taken / `j` / `jal`
- `npc_target`  in  32  target from NPC calculator
- `jr_valid`  in  1  D-stage `jr`/`jalr`
- `jr_target`  in  32  forwarded register value
- `exc_req`  in  1  CP0 exception or interrupt entry (M stage)
- `eret_req`  in  1  `eret` in M stage
- `epc`  in  32  CP0 EPC
- `pc`  out  32  current fetch address (registered)
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32
- `flush`  out  1  clear F/D/E pipeline registers
- `fetch_adel`  out  1  current `pc` misaligned or outside [`IMEM_LO`,`IMEM_HI`]

## Operation
- States: RUN, FLUSH.
- RUN next-PC priority, highest first:
  - `exc_req` → `EXC_VECTOR`, go FLUSH
  - `eret_req` → `epc`, go FLUSH
  - `stall` → hold `pc`
  - `jr_valid` → `jr_target`
  - `npc_op` → `npc_target`
  - else → `pc_plus4`
- FLUSH lasts one cycle. It ignores `stall`, `jr_valid`, `npc_op` and `eret_req`.
  - `exc_req` is still honoured: load `EXC_VECTOR` and stay in FLUSH.
  - Otherwise load `pc_plus4` and return to RUN.
- `flush` = 1 exactly while in FLUSH. Registered; never combinational from inputs.
- `fetch_adel` is combinational from `pc`: `pc[1:0]!=0`, `pc<IMEM_LO` or `pc>IMEM_HI`.
  - Targets are never corrected; a bad `jr_target` or `epc` loads as-is and raises `fetch_adel`.
- `jr_valid` and `npc_op` together: `jr_target` wins. The decoder never produces both; this is a defined fallback.
- `pc_plus4` of 32'hffff_fffc is 32'h0000_0000.

## Timing
- Reset (sync): `pc`=`RESET_PC`, state RUN, `flush`=0, `fetch_adel`=0, `pc_plus4`=`RESET_PC`+4.
- `reset` overrides all inputs in the same edge, including mid-FLUSH.
- Redirect latency is 1 cycle: a request sampled at edge t sets `pc` to its target after edge t.
  - For `exc_req`/`eret_req`, `flush`=1 in the cycle following edge t.
- Stall: `pc` is unchanged for every cycle `stall`=1 in RUN. There is no extra bubble on release.
- `exc_req` while `stall`=1: exception taken; stall ignored.
- `exc_req` with `eret_req`: exception taken.
- Back-to-back `exc_req` in FLUSH: `pc` re-loaded with `EXC_VECTOR`, `flush` stays 1.

## Structure
- Shared package `mips_pkg`:
  - state encoding `PCS_RUN`/`PCS_FLUSH`
  - defaults for `RESET_PC`, `EXC_VECTOR`, `IMEM_LO`, `IMEM_HI`
- Sub-module `pc_next_mux`: the purely combinational priority select. Inputs are state, requests and targets; outputs are next PC and next state.
- `pc_sequencer` holds the PC/state registers, `pc_plus4`, `fetch_adel` and `flush`.

## Test plan
- Reset, then 3 free cycles → `pc` = 0x3000, 0x3004, 0x3008, 0x300c; `flush`=0.
- At `pc`=0x3010, `npc_op`=1, `npc_target`=0x3100 → next `pc`=0x3100. Then `stall`=1 for 2 cycles → `pc` stays 0x3100, then 0x3104.
- At `pc`=0x3020, `exc_req`=1 and `stall`=1 → next `pc`=0x4180, `flush`=1 one cycle. In FLUSH `npc_op`=1, `npc_target`=0x3200 → ignored, `pc`=0x4184, `flush`=0.
- In RUN, `eret_req`=1, `epc`=0x3024, `exc_req`=1 same cycle → `pc`=0x4180. Retry with `eret_req` alone → `pc`=0x3024, `flush`=1.
- `jr_valid`=1, `jr_target`=0x3002 → `pc`=0x3002, `fetch_adel`=1. Then `jr_target`=0x7000 → `fetch_adel`=1. Then `npc_target`=0x6ffc → `fetch_adel`=0.
- In FLUSH, assert `reset` with `exc_req`=1 → `pc`=0x3000, state RUN, `flush`=0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core package: PC sequencer state encoding,
// address defaults and the fetch address check.
package mips_pkg;

  typedef enum logic {
    PCS_RUN   = 1'b0,
    PCS_FLUSH = 1'b1
  } pcs_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_HI    = 32'h0000_6ffc;

  // Bad fetch: misaligned or outside [lo, hi].
  function automatic logic adel_chk(
    input logic [31:0] pc,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between pipeline control and the PC sequencer.
// master: hazard/NPC/CP0 side; slave: pc_sequencer.
interface pc_sequencer_if;

  logic        stall;
  logic        npc_op;
  logic [31:0] npc_target;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        fetch_adel;

  modport master (
    output stall, npc_op, npc_target,
    output jr_valid, jr_target,
    output exc_req, eret_req, epc,
    input  pc, pc_plus4, flush, fetch_adel
  );

  modport slave (
    input  stall, npc_op, npc_target,
    input  jr_valid, jr_target,
    input  exc_req, eret_req, epc,
    output pc, pc_plus4, flush, fetch_adel
  );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC / next-state priority select for the PC sequencer.
// Ports: i_state, requests, targets, i_pc(+4) in; o_npc, o_nstate out.
module pc_next_mux
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  pcs_e        i_state,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_stall,
  input  logic        i_npc_op,
  input  logic [31:0] i_npc_target,
  input  logic        i_jr_valid,
  input  logic [31:0] i_jr_target,
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  output logic [31:0] o_npc,
  output pcs_e        o_nstate
);

  always_comb begin
    o_npc    = i_pc_plus4;
    o_nstate = PCS_RUN;
    if (i_state == PCS_FLUSH) begin
      // Stale D-stage requests are dropped here.
      if (i_exc_req) begin
        o_npc    = EXC_VECTOR;
        o_nstate = PCS_FLUSH;
      end
    end else begin
      priority case (1'b1)
        i_exc_req: begin
          o_npc    = EXC_VECTOR;
          o_nstate = PCS_FLUSH;
        end
        i_eret_req: begin
          o_npc    = i_epc;
          o_nstate = PCS_FLUSH;
        end
        i_stall:    o_npc = i_pc;
        i_jr_valid: o_npc = i_jr_target;
        i_npc_op:   o_npc = i_npc_target;
        default:    o_npc = i_pc_plus4;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: PC/state registers, flush, fetch fault flag.
// Ports: clk, reset (sync, active-high), bus (pc_sequencer_if.slave).
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [31:0] IMEM_LO    = DEF_IMEM_LO,
  parameter logic [31:0] IMEM_HI    = DEF_IMEM_HI
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  logic [31:0] r_pc;
  pcs_e        r_state;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_npc;
  pcs_e        w_nstate;

  assign w_pc_plus4 = r_pc + 32'd4;

  pc_next_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_mux (
    .i_state      (r_state),
    .i_pc         (r_pc),
    .i_pc_plus4   (w_pc_plus4),
    .i_stall      (bus.stall),
    .i_npc_op     (bus.npc_op),
    .i_npc_target (bus.npc_target),
    .i_jr_valid   (bus.jr_valid),
    .i_jr_target  (bus.jr_target),
    .i_exc_req    (bus.exc_req),
    .i_eret_req   (bus.eret_req),
    .i_epc        (bus.epc),
    .o_npc        (w_npc),
    .o_nstate     (w_nstate)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_state <= PCS_RUN;
    end else begin
      r_pc    <= w_npc;
      r_state <= w_nstate;
    end
  end

  // flush decodes the state register only, so it never
  // follows an input combinationally.
  always_comb begin
    bus.flush      = (r_state == PCS_FLUSH);
    bus.pc         = r_pc;
    bus.pc_plus4   = w_pc_plus4;
    bus.fetch_adel = adel_chk(r_pc, IMEM_LO, IMEM_HI);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  pc_sequencer_if u_if ();

  pc_sequencer u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    u_if.stall      = 1'b0;
    u_if.npc_op     = 1'b0;
    u_if.npc_target = 32'h0;
    u_if.jr_valid   = 1'b0;
    u_if.jr_target  = 32'h0;
    u_if.exc_req    = 1'b0;
    u_if.eret_req   = 1'b0;
    u_if.epc        = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic see(
    input string       tag,
    input logic [31:0] pc,
    input logic        fl
  );
    chk({tag, "_pc"}, u_if.pc, pc);
    chk({tag, "_fl"}, {31'd0, u_if.flush}, {31'd0, fl});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    reset = 1'b1;
    step();
    see("rst", 32'h3000, 1'b0);
    chk("rst_p4", u_if.pc_plus4, 32'h3004);
    chk("rst_adel", {31'd0, u_if.fetch_adel}, 32'd0);
    reset = 1'b0;

    step(); see("seq1", 32'h3004, 1'b0);
    step(); see("seq2", 32'h3008, 1'b0);
    step(); see("seq3", 32'h300c, 1'b0);
    step(); see("seq4", 32'h3010, 1'b0);

    u_if.npc_op = 1'b1; u_if.npc_target = 32'h3100;
    step(); see("npc", 32'h3100, 1'b0);
    idle(); u_if.stall = 1'b1;
    step(); see("stl1", 32'h3100, 1'b0);
    step(); see("stl2", 32'h3100, 1'b0);
    idle();
    step(); see("stl_rel", 32'h3104, 1'b0);

    u_if.npc_op = 1'b1; u_if.npc_target = 32'h3020;
    step(); see("to3020", 32'h3020, 1'b0);
    idle(); u_if.exc_req = 1'b1; u_if.stall = 1'b1;
    step(); see("exc_stl", 32'h4180, 1'b1);
    idle(); u_if.npc_op = 1'b1; u_if.npc_target = 32'h3200;
    u_if.stall = 1'b1; u_if.eret_req = 1'b1; u_if.epc = 32'h3300;
    step(); see("fl_ign", 32'h4184, 1'b0);

    idle(); u_if.eret_req = 1'b1; u_if.epc = 32'h3024;
    u_if.exc_req = 1'b1;
    step(); see("exc_eret", 32'h4180, 1'b1);
    idle();
    step(); see("fl_out", 32'h4184, 1'b0);
    u_if.eret_req = 1'b1; u_if.epc = 32'h3024;
    step(); see("eret", 32'h3024, 1'b1);
    idle();
    step(); see("eret_nx", 32'h3028, 1'b0);

    u_if.jr_valid = 1'b1; u_if.jr_target = 32'h3002;
    step(); see("jr_mis", 32'h3002, 1'b0);
    chk("adel_mis", {31'd0, u_if.fetch_adel}, 32'd1);
    u_if.jr_target = 32'h7000;
    step(); chk("adel_hi", {31'd0, u_if.fetch_adel}, 32'd1);
    chk("jr_hi", u_if.pc, 32'h7000);
    idle(); u_if.npc_op = 1'b1; u_if.npc_target = 32'h6ffc;
    step(); chk("adel_top", {31'd0, u_if.fetch_adel}, 32'd0);
    u_if.npc_target = 32'h2ffc;
    step(); chk("adel_lo", {31'd0, u_if.fetch_adel}, 32'd1);

    idle(); u_if.jr_valid = 1'b1; u_if.jr_target = 32'h3400;
    u_if.npc_op = 1'b1; u_if.npc_target = 32'h3500;
    step(); see("jr_win", 32'h3400, 1'b0);

    idle(); u_if.jr_valid = 1'b1; u_if.jr_target = 32'hffff_fffc;
    step(); chk("wrap_p4", u_if.pc_plus4, 32'h0000_0000);
    idle();
    step(); chk("wrap_pc", u_if.pc, 32'h0000_0000);

    u_if.exc_req = 1'b1;
    step(); see("exc1", 32'h4180, 1'b1);
    step(); see("exc2", 32'h4180, 1'b1);
    reset = 1'b1;
    step(); see("rst_fl", 32'h3000, 1'b0);
    reset = 1'b0; idle();
    step(); see("rst_run", 32'h3004, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
